// File: rtl/button_cmd_encoder_pkg.sv
// Shared types and helpers for the button/switch command front-end.
package cmd_pkg;

  typedef enum logic [1:0] {IDLE, PRESS, HELD, ARM} a_state_t;
  typedef enum logic [1:0] {P_IDLE, P_HIGH, P_GAP} p_state_t;
  typedef enum logic {CMD_RESET, CMD_LOAD} cmd_sel_t;

  function automatic int ms_to_ticks(input int f_clk_hz, input int ms);
    int t;
    t = (f_clk_hz / 1000) * ms;
    return (t < 1) ? 1 : t;
  endfunction

endpackage

// File: rtl/button_cmd_encoder_debounce.sv
// 2-FF synchronizer plus stability counter; output follows the input once it
// has been seen unchanged for DB_TKS consecutive synchronized samples.
module debounce #(
  parameter int W      = 1,
  parameter int DB_TKS = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] raw_i,
  output logic [W-1:0] db_o
);

  localparam int CW = $clog2(DB_TKS + 1);

  logic [W-1:0]  sync1_q, sync2_q, cand_q, db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The first sample of a new value counts as 1, so a clean edge lands after 2 + DB_TKS cycles.
  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (sync2_q != cand_q) begin
      cnt_d = CW'(1);
    end else if (cnt_q != CW'(DB_TKS)) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (cnt_d == CW'(DB_TKS)) begin
      db_d = sync2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      db_q    <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      cand_q  <= sync2_q;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/button_cmd_encoder.sv
// Debounces board buttons/switches, classifies button-A presses as short (load)
// or long (reset), and emits fixed-width command pulses with a guard gap.
module button_cmd_encoder
  import cmd_pkg::*;
#(
  parameter int F_CLK_HZ    = 25_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int PULSE_CYC   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_a,
  input  logic       btn_b,
  input  logic       sw_dir,
  input  logic       sw_modo,
  input  logic [8:0] sw_data,
  output logic       reset,
  output logic       load,
  output logic       pause,
  output logic       dir,
  output logic       modo,
  output logic [8:0] data_out,
  output logic       busy
);

  localparam int DB_TKS   = ms_to_ticks(F_CLK_HZ, DEBOUNCE_MS);
  localparam int LONG_TKS = ms_to_ticks(F_CLK_HZ, LONG_MS);
  localparam int HW       = $clog2(LONG_TKS + 1);
  localparam int PW       = $clog2(PULSE_CYC + 1);

  logic       db_a, db_b, db_dir, db_modo;
  logic [8:0] db_data;

  debounce #(.W(1), .DB_TKS(DB_TKS)) u_db_a    (.clk(clk), .rst_n(rst_n), .raw_i(btn_a),   .db_o(db_a));
  debounce #(.W(1), .DB_TKS(DB_TKS)) u_db_b    (.clk(clk), .rst_n(rst_n), .raw_i(btn_b),   .db_o(db_b));
  debounce #(.W(1), .DB_TKS(DB_TKS)) u_db_dir  (.clk(clk), .rst_n(rst_n), .raw_i(sw_dir),  .db_o(db_dir));
  debounce #(.W(1), .DB_TKS(DB_TKS)) u_db_modo (.clk(clk), .rst_n(rst_n), .raw_i(sw_modo), .db_o(db_modo));
  debounce #(.W(9), .DB_TKS(DB_TKS)) u_db_data (.clk(clk), .rst_n(rst_n), .raw_i(sw_data), .db_o(db_data));

  a_state_t      a_state_q, a_state_d;
  p_state_t      p_state_q, p_state_d;
  cmd_sel_t      sel_q, sel_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [PW-1:0] p_cnt_q, p_cnt_d;
  logic [8:0]    data_q, data_d;
  logic          a_prev_q, b_prev_q, pause_q, dir_q, modo_q, rst_pend_q, rst_pend_d;
  logic          rst_req, load_req, p_free, start_rst, start_load;

  // The generator accepts a new command in its last gap cycle so busy never dips between pulses.
  assign p_free = (p_state_q == P_IDLE) ||
                  ((p_state_q == P_GAP) && (p_cnt_q == PW'(PULSE_CYC - 1)));

  always_comb begin
    a_state_d = a_state_q;
    hold_d    = hold_q;
    data_d    = data_q;
    rst_req   = 1'b0;
    load_req  = 1'b0;
    case (a_state_q)
      IDLE: if (db_a && !a_prev_q) begin
        a_state_d = PRESS;
        hold_d    = '0;
      end
      PRESS: begin
        hold_d = hold_q + 1'b1;
        if (hold_q == HW'(LONG_TKS - 1)) begin
          rst_req   = 1'b1;
          a_state_d = HELD;
        end else if (!db_a) begin
          a_state_d = ARM;
          data_d    = db_data;
        end
      end
      HELD: if (!db_a) a_state_d = IDLE;
      ARM: begin
        // data_out is frozen in the firing cycle, giving one cycle of setup before load rises.
        if (p_free && !rst_pend_q) begin
          load_req  = 1'b1;
          a_state_d = IDLE;
        end else begin
          data_d = db_data;
        end
      end
      default: a_state_d = IDLE;
    endcase
  end

  always_comb begin
    p_state_d  = p_state_q;
    p_cnt_d    = p_cnt_q;
    sel_d      = sel_q;
    start_rst  = p_free && (rst_req || rst_pend_q);
    start_load = p_free && load_req && !start_rst;
    rst_pend_d = rst_pend_q;
    if (start_rst) rst_pend_d = 1'b0;
    else if (rst_req) rst_pend_d = 1'b1;
    case (p_state_q)
      P_HIGH, P_GAP: begin
        if (p_cnt_q == PW'(PULSE_CYC - 1)) begin
          p_state_d = (p_state_q == P_HIGH) ? P_GAP : P_IDLE;
          p_cnt_d   = '0;
        end else begin
          p_cnt_d = p_cnt_q + 1'b1;
        end
      end
      default: p_state_d = P_IDLE;
    endcase
    if (start_rst || start_load) begin
      p_state_d = P_HIGH;
      p_cnt_d   = '0;
      sel_d     = start_rst ? CMD_RESET : CMD_LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_state_q  <= IDLE;
      p_state_q  <= P_IDLE;
      sel_q      <= CMD_RESET;
      hold_q     <= '0;
      p_cnt_q    <= '0;
      data_q     <= '0;
      a_prev_q   <= 1'b0;
      b_prev_q   <= 1'b0;
      pause_q    <= 1'b0;
      dir_q      <= 1'b0;
      modo_q     <= 1'b0;
      rst_pend_q <= 1'b0;
    end else begin
      a_state_q  <= a_state_d;
      p_state_q  <= p_state_d;
      sel_q      <= sel_d;
      hold_q     <= hold_d;
      p_cnt_q    <= p_cnt_d;
      data_q     <= data_d;
      a_prev_q   <= db_a;
      b_prev_q   <= db_b;
      pause_q    <= pause_q ^ (db_b & ~b_prev_q);
      dir_q      <= db_dir;
      modo_q     <= db_modo;
      rst_pend_q <= rst_pend_d;
    end
  end

  assign reset    = (p_state_q == P_HIGH) && (sel_q == CMD_RESET);
  assign load     = (p_state_q == P_HIGH) && (sel_q == CMD_LOAD);
  assign busy     = (p_state_q != P_IDLE);
  assign pause    = pause_q;
  assign dir      = dir_q;
  assign modo     = modo_q;
  assign data_out = data_q;

endmodule
